spi_phy: RTL and testbench
==========================

SPI_PHY -- requirements
Module: spi_phy

Interface
REQ-001 Parameter CLK_DIV, default 2, clk cycles per SCK half-period; legal range 1..255.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 spi_mosi  input  32  transmit word; narrow uses [7:0], wide uses [31:0].
REQ-005 spi_begin  input  1  level request; accepted only while spi_busy=0.
REQ-006 spi_wide  input  1  1=32-bit transfer, 0=8-bit transfer; sampled at acceptance.
REQ-007 spi_cs  input  1  requested chip-select level (1=deselect).
REQ-008 spi_busy  output  1  transfer in progress.
REQ-009 sck  output  1  SPI clock pin, idle low.
REQ-010 mosi  output  1  SPI data pin.
REQ-011 cs_n  output  1  chip-select pin.
REQ-012 miso  input  1  SPI read pin (present only with SPI_PHY_MISO_EN).
REQ-013 spi_miso  output  32  received word (present only with SPI_PHY_MISO_EN).

Function
REQ-014 SPI mode 0, MSB first; mosi changes only while sck is low; sck rising edge is the sample point.
REQ-015 States: IDLE, SHIFT_LO (sck=0), SHIFT_HI (sck=1); all outputs registered.
REQ-016 IDLE with spi_begin=1 at edge N: latch spi_mosi, spi_wide, spi_cs; at N+1 spi_busy=1, state SHIFT_LO, mosi = first bit (bit 7 narrow, bit 31 wide).
REQ-017 Bit count NB = 8 (narrow) or 32 (wide); half-period counter 8 bits, reloads each phase.
REQ-018 SHIFT_LO lasts CLK_DIV cycles, then SHIFT_HI (sck=1) for CLK_DIV cycles; at end of SHIFT_HI, the next bit goes on mosi and state returns to SHIFT_LO, or to IDLE after the last bit.
REQ-019 spi_busy stays high for exactly 2*CLK_DIV*NB consecutive cycles, then drops with sck=0 in the same cycle.
REQ-020 spi_begin held high while busy is ignored; spi_begin still high in the first IDLE cycle starts a new transfer (level-sensitive, no edge detect).
REQ-021 IDLE: cs_n = spi_cs delayed one cycle; during a transfer, cs_n holds the value latched at acceptance; spi_cs changes mid-transfer take effect after busy drops.
REQ-022 IDLE: mosi holds the last driven bit; sck=0.
REQ-023 spi_mosi and spi_wide changes during a transfer do not affect it.

Reset
REQ-024 rst_n low asynchronously forces IDLE, sck=0, mosi=0, cs_n=1, spi_busy=0, counters 0, spi_miso=0.
REQ-025 Reset mid-transfer aborts immediately with no partial completion; after release, the first rising edge with spi_begin=1 starts a fresh transfer.

Configuration
REQ-026 Macro SPI_PHY_MISO_EN defined: miso port present; miso sampled on each sck rising edge into a shift register.
REQ-027 With SPI_PHY_MISO_EN: spi_miso updates in the cycle busy drops; narrow result is in [7:0] with [31:8]=0, wide result uses all 32 bits; it holds until the next completion.
REQ-028 Macro undefined: miso and spi_miso ports absent, no receive logic; transmit timing identical.

Verification
REQ-029 CLK_DIV=2, narrow, spi_mosi=0x000000A5, begin 1 cycle -> busy high 32 cycles, 8 sck pulses, mosi bits 1,0,1,0,0,1,0,1 at rising edges, cs_n=spi_cs.
REQ-030 CLK_DIV=1, wide, spi_mosi=0xDEADBEEF -> busy 64 cycles, 32 sck pulses, captured bits equal 0xDEADBEEF.
REQ-031 begin held high 3 cycles after busy rises, then low -> exactly one transfer; begin held high continuously -> back-to-back transfers with one IDLE cycle between them.
REQ-032 spi_cs toggled 0->1 mid-transfer -> cs_n stays 0 until busy drops, then goes 1 one cycle later.
REQ-033 rst_n pulsed low at bit 4 of a wide transfer -> sck=0, cs_n=1, busy=0 immediately; a subsequent narrow 0x3C transfer is correct.
REQ-034 SPI_PHY_MISO_EN, miso loopback from mosi, narrow 0x5A -> spi_miso=0x0000005A when busy drops.

Source files
------------

// File: rtl/spi_phy.sv
// SPI mode-0 master PHY: 8- or 32-bit MSB-first transfers with a programmable SCK half-period.
// Optional receive path (miso / spi_miso) is built only when SPI_PHY_MISO_EN is defined.
module spi_phy #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] spi_mosi,
    input  logic        spi_begin,
    input  logic        spi_wide,
    input  logic        spi_cs,
    output logic        spi_busy,
    output logic        sck,
    output logic        mosi,
    output logic        cs_n
`ifdef SPI_PHY_MISO_EN
    ,
    input  logic        miso,
    output logic [31:0] spi_miso
`endif
);

    localparam logic [7:0] HALF_RELOAD = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI
    } state_t;

    state_t      state;
    logic [31:0] shreg;
    logic [4:0]  bit_cnt;
    logic [7:0]  half_cnt;
`ifdef SPI_PHY_MISO_EN
    logic        wide;
    logic [31:0] rx_sh;
`endif

    // shreg holds the bits still to be sent, MSB-aligned; mosi already carries the current bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            spi_busy <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            half_cnt <= '0;
`ifdef SPI_PHY_MISO_EN
            wide     <= 1'b0;
            rx_sh    <= '0;
            spi_miso <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    sck  <= 1'b0;
                    cs_n <= spi_cs;
                    if (spi_begin) begin
                        spi_busy <= 1'b1;
                        state    <= SHIFT_LO;
                        half_cnt <= HALF_RELOAD;
`ifdef SPI_PHY_MISO_EN
                        wide     <= spi_wide;
`endif
                        if (spi_wide) begin
                            bit_cnt <= 5'd31;
                            mosi    <= spi_mosi[31];
                            shreg   <= {spi_mosi[30:0], 1'b0};
                        end else begin
                            bit_cnt <= 5'd7;
                            mosi    <= spi_mosi[7];
                            shreg   <= {spi_mosi[6:0], 25'b0};
                        end
                    end
                end
                SHIFT_LO: begin
                    if (half_cnt == '0) begin
                        sck      <= 1'b1;
                        state    <= SHIFT_HI;
                        half_cnt <= HALF_RELOAD;
`ifdef SPI_PHY_MISO_EN
                        rx_sh    <= {rx_sh[30:0], miso};
`endif
                    end else begin
                        half_cnt <= half_cnt - 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (half_cnt == '0) begin
                        sck <= 1'b0;
                        if (bit_cnt == '0) begin
                            state    <= IDLE;
                            spi_busy <= 1'b0;
                            half_cnt <= '0;
`ifdef SPI_PHY_MISO_EN
                            spi_miso <= wide ? rx_sh : {24'h0, rx_sh[7:0]};
`endif
                        end else begin
                            state    <= SHIFT_LO;
                            half_cnt <= HALF_RELOAD;
                            bit_cnt  <= bit_cnt - 5'd1;
                            mosi     <= shreg[31];
                            shreg    <= {shreg[30:0], 1'b0};
                        end
                    end else begin
                        half_cnt <= half_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_phy.sv
// Scoreboard bench for spi_phy: two instances (CLK_DIV=2 and CLK_DIV=1); stimulus queues
// expected transfers, a negedge monitor reconstructs each transfer from the pins and compares.
module tb_spi_phy;

    logic              clk;
    logic              rst_n;
    logic [1:0]        sbegin, swide, scs;
    logic [1:0][31:0]  smosi;
    logic [1:0]        busy, sck, mosi_o, cs_n;
`ifdef SPI_PHY_MISO_EN
    logic [1:0][31:0]  smiso;
`endif

    spi_phy #(.CLK_DIV(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .spi_mosi(smosi[0]), .spi_begin(sbegin[0]),
        .spi_wide(swide[0]), .spi_cs(scs[0]), .spi_busy(busy[0]), .sck(sck[0]),
        .mosi(mosi_o[0]), .cs_n(cs_n[0])
`ifdef SPI_PHY_MISO_EN
        , .miso(mosi_o[0]), .spi_miso(smiso[0])
`endif
    );

    spi_phy #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .spi_mosi(smosi[1]), .spi_begin(sbegin[1]),
        .spi_wide(swide[1]), .spi_cs(scs[1]), .spi_busy(busy[1]), .sck(sck[1]),
        .mosi(mosi_o[1]), .cs_n(cs_n[1])
`ifdef SPI_PHY_MISO_EN
        , .miso(mosi_o[1]), .spi_miso(smiso[1])
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          dut;
        logic [31:0] bits;
        logic        wide;
        logic        cs;
        int          len;
        int          pulses;
        int          gap;
    } xfer_t;

    xfer_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic xfer_t mk(input int dut, input logic [31:0] bits, input logic wide,
                                 input logic cs, input int len, input int pulses, input int gap);
        xfer_t x;
        x.dut = dut; x.bits = bits; x.wide = wide; x.cs = cs;
        x.len = len; x.pulses = pulses; x.gap = gap;
        return x;
    endfunction

    // Monitor state, one slot per DUT
    xfer_t       cur[2];
    logic        active[2], have[2], sck_prev[2], mosi_prev[2];
    int          blen[2], npulse[2], gap[2], viol[2], csbad[2];
    logic [31:0] cap[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                active[i] = 1'b0; have[i] = 1'b0; gap[i] = 0;
                sck_prev[i] = 1'b0; mosi_prev[i] = 1'b0;
            end else begin
                if (busy[i]) begin
                    if (!active[i]) begin
                        active[i] = 1'b1;
                        blen[i] = 0; npulse[i] = 0; cap[i] = '0; viol[i] = 0; csbad[i] = 0;
                        if (exp_q.size() > 0 && exp_q[0].dut == i) begin
                            cur[i] = exp_q.pop_front();
                            have[i] = 1'b1;
                        end else begin
                            have[i] = 1'b0;
                        end
                        chk($sformatf("xfer_expected_dut%0d", i), 32'(have[i]), 32'd1);
                        if (have[i] && cur[i].gap != 0)
                            chk($sformatf("idle_gap_dut%0d", i), 32'(gap[i]), 32'(cur[i].gap));
                    end
                    blen[i]++;
                    if (sck[i] && !sck_prev[i]) begin
                        npulse[i]++;
                        cap[i] = {cap[i][30:0], mosi_o[i]};
                    end
                    if (sck[i] && mosi_o[i] !== mosi_prev[i]) viol[i]++;
                    if (have[i] && cs_n[i] !== cur[i].cs) csbad[i]++;
                end else begin
                    if (active[i]) begin
                        active[i] = 1'b0;
                        if (have[i]) begin
                            chk($sformatf("busy_len_dut%0d", i), 32'(blen[i]), 32'(cur[i].len));
                            chk($sformatf("sck_pulses_dut%0d", i), 32'(npulse[i]), 32'(cur[i].pulses));
                            chk($sformatf("mosi_bits_dut%0d", i), cap[i], cur[i].bits);
                            chk($sformatf("mosi_stable_dut%0d", i), 32'(viol[i]), 32'd0);
                            chk($sformatf("cs_hold_dut%0d", i), 32'(csbad[i]), 32'd0);
                            chk($sformatf("cs_at_drop_dut%0d", i), 32'(cs_n[i]), 32'(cur[i].cs));
                            chk($sformatf("sck_at_drop_dut%0d", i), 32'(sck[i]), 32'd0);
`ifdef SPI_PHY_MISO_EN
                            chk($sformatf("spi_miso_dut%0d", i), smiso[i],
                                cur[i].wide ? cur[i].bits : {24'h0, cur[i].bits[7:0]});
`endif
                        end
                        have[i] = 1'b0;
                        gap[i] = 0;
                    end
                    gap[i]++;
                end
                sck_prev[i]  = sck[i];
                mosi_prev[i] = mosi_o[i];
            end
        end
    end

    task automatic start(input int i, input logic [31:0] d, input logic w, input logic c);
        @(negedge clk);
        smosi[i] = d; swide[i] = w; scs[i] = c; sbegin[i] = 1'b1;
        @(negedge clk);
        sbegin[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while (busy[i] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk($sformatf("busy_rise_dut%0d", i), 32'(busy[i]), 32'd1);
        n = 0;
        while (busy[i] === 1'b1 && n < 400) begin @(negedge clk); n++; end
        chk($sformatf("busy_fall_dut%0d", i), 32'(busy[i]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        sbegin = '0; swide = '0; scs = '1; smosi = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_sck", 32'(sck[0]), 32'd0);
        chk("rst_mosi", 32'(mosi_o[0]), 32'd0);
        chk("rst_cs_n", 32'(cs_n[0]), 32'd1);
        #1 rst_n = 1'b1;
        scs[0] = 1'b0;
        @(negedge clk);
        chk("idle_cs_follow", 32'(cs_n[0]), 32'd0);

        // Narrow 0xA5, CLK_DIV=2: 32 busy cycles, 8 pulses
        exp_q.push_back(mk(0, 32'h0000_00A5, 1'b0, 1'b0, 32, 8, 0));
        start(0, 32'h0000_00A5, 1'b0, 1'b0);
        wait_done(0);
        chk("idle_mosi_last", 32'(mosi_o[0]), 32'd1);
        chk("idle_sck", 32'(sck[0]), 32'd0);

        // Narrow 0x5A with chip-select deasserted level
        exp_q.push_back(mk(0, 32'h0000_005A, 1'b0, 1'b1, 32, 8, 0));
        start(0, 32'hFFFF_FF5A, 1'b0, 1'b1);
        wait_done(0);
        chk("idle_mosi_last2", 32'(mosi_o[0]), 32'd0);

        // Wide 0xDEADBEEF, CLK_DIV=1; inputs scrambled mid-transfer
        exp_q.push_back(mk(1, 32'hDEAD_BEEF, 1'b1, 1'b0, 64, 32, 0));
        start(1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        smosi[1] = '0; swide[1] = 1'b0;
        wait_done(1);

        // begin held 3 cycles after busy rises: single transfer only
        exp_q.push_back(mk(0, 32'h0000_00C3, 1'b0, 1'b0, 32, 8, 0));
        @(negedge clk);
        smosi[0] = 32'h0000_00C3; swide[0] = 1'b0; scs[0] = 1'b0; sbegin[0] = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        sbegin[0] = 1'b0;
        wait_done(0);
        repeat (6) @(negedge clk);
        chk("held_single", 32'(busy[0]), 32'd0);

        // begin held continuously: back-to-back with one idle cycle
        for (int k = 0; k < 3; k++)
            exp_q.push_back(mk(1, 32'h0000_0081, 1'b0, 1'b0, 16, 8, (k == 0) ? 0 : 1));
        @(negedge clk);
        smosi[1] = 32'h0000_0081; swide[1] = 1'b0; scs[1] = 1'b0; sbegin[1] = 1'b1;
        for (int k = 0; k < 3; k++) wait_done(1);
        sbegin[1] = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_stop", 32'(busy[1]), 32'd0);

        // spi_cs toggled mid-transfer
        exp_q.push_back(mk(0, 32'h0000_0096, 1'b0, 1'b0, 32, 8, 0));
        start(0, 32'h0000_0096, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        scs[0] = 1'b1;
        wait_done(0);
        chk("cs_n_hold_at_drop", 32'(cs_n[0]), 32'd0);
        @(negedge clk);
        chk("cs_n_after_drop", 32'(cs_n[0]), 32'd1);
        scs[0] = 1'b0;

        // Reset during bit 4 of a wide transfer (sck high, mosi=1, cs_n=0)
        exp_q.push_back(mk(0, 32'h0F0F_0F0F, 1'b1, 1'b0, 128, 32, 0));
        start(0, 32'h0F0F_0F0F, 1'b1, 1'b0);
        repeat (18) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_sck", 32'(sck[0]), 32'd0);
        chk("abort_cs_n", 32'(cs_n[0]), 32'd1);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_mosi", 32'(mosi_o[0]), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        exp_q.push_back(mk(0, 32'h0000_003C, 1'b0, 1'b0, 32, 8, 0));
        start(0, 32'h0000_003C, 1'b0, 1'b0);
        wait_done(0);

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
